// File: rtl/filter_mc.sv
// filter_mc: multi-channel time-multiplexed complex FIR.
// NCHAN interleaved channels share one complex-by-real MAC and one tap set,
// each channel keeps its own sample history. Taps arrive over the message
// bus into a shadow bank and are committed only while the MAC is idle.
//
// Load FSM states
//   state    | meaning
//   S_IDLE   | no tap load in progress
//   S_LOAD   | writing shadow taps, ld_idx is the next tap index
//   S_COMMIT | shadow bank complete, waiting for the MAC to go idle

`ifndef MSG_WIDTH
`define MSG_WIDTH 32
`endif

module filter_mc #(
    parameter int WIDTH  = 32,
    parameter int MWIDTH = 1,
    parameter int FLTLEN = 10,
    parameter int NCHAN  = 4,
    parameter int ID     = 0,
    localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [CW-1:0]         in_ch,
    input  logic                  in_nd,
    input  logic [MWIDTH-1:0]     in_m,
    output logic                  in_ready,
    input  logic [`MSG_WIDTH-1:0] in_msg,
    input  logic                  in_msg_nd,
    output logic [WIDTH-1:0]      out_data,
    output logic [CW-1:0]         out_ch,
    output logic                  out_nd,
    output logic [MWIDTH-1:0]     out_m,
    output logic [`MSG_WIDTH-1:0] out_msg,
    output logic                  out_msg_nd,
    output logic                  error
);

    localparam int HW = WIDTH / 2;
    localparam int KW = $clog2(FLTLEN);
    localparam int PW = 2 * HW;
    localparam int AW = PW + $clog2(FLTLEN);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} ld_state_t;

    ld_state_t state, state_nxt;

    logic                 busy;
    logic [KW-1:0]        cnt;
    logic [WIDTH-1:0]     cur_data;
    logic [CW-1:0]        cur_ch;
    logic [MWIDTH-1:0]    cur_m;
    logic signed [AW-1:0] acc_re, acc_im;
    logic [WIDTH-1:0]     hist [NCHAN][FLTLEN-1];

    logic signed [HW-1:0] tap_act [FLTLEN];
    logic signed [HW-1:0] tap_shd [FLTLEN];
    logic [KW-1:0]        ld_idx;

    logic                 ch_ok, accept, drop, mac_last;
    logic [WIDTH-1:0]     op;
    logic signed [HW-1:0] op_re, op_im, tap_cur;
    logic signed [PW-1:0] prod_re, prod_im;
    logic signed [AW-1:0] sum_re, sum_im;
    logic [HW:0]          sat_re, sat_im;

    logic is_hdr, hdr_match, is_data;
    logic idx_clr, shd_we, commit, hdr_err;
    logic unused_msg;

    // Truncate the Q-format shift and clamp to HW bits; MSB of result flags overflow.
    function automatic logic [HW:0] sat_fn(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] sh;
        logic [AW-HW:0]       top;
        sh  = v >>> (HW - 1);
        top = sh[AW-1:HW-1];
        if ((&top) || (~|top))
            return {1'b0, sh[HW-1:0]};
        else if (sh[AW-1])
            return {1'b1, 1'b1, {(HW-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(HW-1){1'b1}}};
    endfunction

    assign in_ready   = !busy;
    assign ch_ok      = int'(in_ch) < NCHAN;
    assign accept     = in_nd && !busy && ch_ok;
    assign drop       = in_nd && (busy || !ch_ok);
    assign mac_last   = busy && (cnt == KW'(FLTLEN - 1));

    assign is_hdr     = in_msg_nd && in_msg[`MSG_WIDTH-1];
    assign hdr_match  = is_hdr && (in_msg[7:0] == 8'(ID));
    assign is_data    = in_msg_nd && !in_msg[`MSG_WIDTH-1];
    assign unused_msg = ^in_msg;

    // Select the operand for this MAC step: the new sample for tap 0, history otherwise.
    always_comb begin
        op      = cur_data;
        tap_cur = tap_act[cnt];
        for (int k = 1; k < FLTLEN; k++) begin
            if (cnt == KW'(k))
                op = hist[cur_ch][k-1];
        end
        op_re   = op[WIDTH-1:HW];
        op_im   = op[HW-1:0];
        prod_re = PW'(op_re) * PW'(tap_cur);
        prod_im = PW'(op_im) * PW'(tap_cur);
        sum_re  = acc_re + AW'(prod_re);
        sum_im  = acc_im + AW'(prod_im);
        sat_re  = sat_fn(sum_re);
        sat_im  = sat_fn(sum_im);
    end

    // MAC sequencing, output register and per-channel history shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            cur_data <= '0;
            cur_ch   <= '0;
            cur_m    <= '0;
            acc_re   <= '0;
            acc_im   <= '0;
            out_nd   <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
            out_m    <= '0;
            for (int c = 0; c < NCHAN; c++)
                for (int k = 0; k < FLTLEN - 1; k++)
                    hist[c][k] <= '0;
        end else begin
            out_nd <= 1'b0;
            if (accept) begin
                busy     <= 1'b1;
                cnt      <= '0;
                cur_data <= in_data;
                cur_ch   <= in_ch;
                cur_m    <= in_m;
                acc_re   <= '0;
                acc_im   <= '0;
            end else if (mac_last) begin
                busy     <= 1'b0;
                out_nd   <= 1'b1;
                out_data <= {sat_re[HW-1:0], sat_im[HW-1:0]};
                out_ch   <= cur_ch;
                out_m    <= cur_m;
                for (int k = FLTLEN - 2; k >= 1; k--)
                    hist[cur_ch][k] <= hist[cur_ch][k-1];
                hist[cur_ch][0] <= cur_data;
            end else if (busy) begin
                cnt    <= cnt + KW'(1);
                acc_re <= sum_re;
                acc_im <= sum_im;
            end
        end
    end

    // Sticky error: dropped samples, saturation, header restart mid-load.
    always_ff @(posedge clk) begin
        if (rst)
            error <= 1'b0;
        else if (drop || hdr_err || (mac_last && (sat_re[HW] || sat_im[HW])))
            error <= 1'b1;
    end

    // Message bus pass-through, one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_msg    <= '0;
            out_msg_nd <= 1'b0;
        end else begin
            out_msg    <= in_msg;
            out_msg_nd <= in_msg_nd;
        end
    end

    // Load FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Load FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (hdr_match)
                    state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (hdr_match)
                    state_nxt = S_LOAD;
                else if (is_hdr)
                    state_nxt = S_IDLE;
                else if (is_data && (ld_idx == KW'(FLTLEN - 1)))
                    state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                if (hdr_match)
                    state_nxt = S_LOAD;
                else if (!busy)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Load FSM outputs; a new matching header always wins over a pending commit.
    always_comb begin
        idx_clr = hdr_match;
        shd_we  = (state == S_LOAD) && is_data;
        commit  = (state == S_COMMIT) && !hdr_match && !busy;
        hdr_err = (state == S_LOAD) && hdr_match;
    end

    // Shadow tap writes and atomic commit into the active bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_idx <= '0;
            for (int k = 0; k < FLTLEN; k++) begin
                tap_act[k] <= '0;
                tap_shd[k] <= '0;
            end
        end else begin
            if (idx_clr)
                ld_idx <= '0;
            else if (shd_we) begin
                ld_idx          <= ld_idx + KW'(1);
                tap_shd[ld_idx] <= in_msg[HW-1:0];
            end
            if (commit)
                for (int k = 0; k < FLTLEN; k++)
                    tap_act[k] <= tap_shd[k];
        end
    end

endmodule
